sub_clock_dyn: RTL and testbench

Runtime-programmable clock divider. It generates a square-wave enable/clock `OUTCLK` at a requested frequency `Freq` (Hz), derived from the system clock `CLK` of known frequency `CLK_HZ`. It sits between control logic that chooses a rate (baud/blink/tone generators) and the consumers of that rate. The half-period count is recomputed in hardware by a sequential divider whenever `Freq` changes.

---
 rtl/sub_clock_dyn.sv | 151 +++++++++++++++
 tb/tb_sub_clock_dyn.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sub_clock_dyn.sv
`default_nettype none
// ============================================================================
// Module  : sub_clock_dyn
// Purpose : Runtime-programmable square-wave divider; the half-period is
//           recomputed by a 32-step restoring divider whenever Freq changes.
//           Optional macro SUBCLK_PHASE_RESTART_EN: apply new rate at once.
// Rev     : 1.0  initial release
// ============================================================================
module sub_clock_dyn #(
    parameter logic [31:0] CLK_HZ = 32'd50_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [25:0] Freq,
    output logic        OUTCLK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t  r_state;
    div_state_t  w_state_next;

    logic [25:0] r_freq_q;
    logic [25:0] r_last_freq;
    logic [26:0] r_den;
    logic [27:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_iter;
    logic [31:0] r_half_cur;
    logic [31:0] r_half_next;
    logic [31:0] r_cnt;
    logic        r_pending;
    logic        r_out;

    logic        w_change;
    logic        w_start;
    logic        w_zero;
    logic [27:0] w_shift;
    logic [28:0] w_sub;
    logic        w_ge;
    logic [31:0] w_result;

    assign w_change = (r_freq_q != r_last_freq);
    assign w_start  = w_change && (r_freq_q != 26'd0);
    assign w_zero   = w_change && (r_freq_q == 26'd0);

    // Dividend bits shift out of the quotient register's MSB as quotient bits shift in
    assign w_shift  = {r_rem[26:0], r_quo[31]};
    assign w_sub    = {1'b0, w_shift} - {2'b00, r_den};
    assign w_ge     = ~w_sub[28];
    assign w_result = (r_quo == 32'd0) ? 32'd1 : r_quo;

    assign OUTCLK   = r_out;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = S_BUSY;
        end else if (w_zero) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_BUSY:  if (r_iter == 5'd31) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_freq_q    <= 26'd0;
            r_last_freq <= 26'd0;
            r_den       <= 27'd0;
            r_rem       <= 28'd0;
            r_quo       <= 32'd0;
            r_iter      <= 5'd0;
            r_half_cur  <= 32'd0;
            r_half_next <= 32'd0;
            r_cnt       <= 32'd0;
            r_pending   <= 1'b0;
            r_out       <= 1'b0;
        end else begin
            r_freq_q <= Freq;
            if (w_change) begin
                r_last_freq <= r_freq_q;
            end

            if (w_start) begin
                r_den  <= {r_freq_q, 1'b0};
                r_rem  <= 28'd0;
                r_quo  <= CLK_HZ;
                r_iter <= 5'd0;
            end else if (r_state == S_BUSY) begin
                r_rem  <= w_ge ? w_sub[27:0] : w_shift;
                r_quo  <= {r_quo[30:0], w_ge};
                r_iter <= r_iter + 5'd1;
            end

            if (r_half_cur == 32'd0) begin
                r_out <= 1'b0;
                r_cnt <= 32'd0;
                if (r_pending) begin
                    r_half_cur <= r_half_next;
                    r_pending  <= 1'b0;
                end
`ifdef SUBCLK_PHASE_RESTART_EN
            end else if (r_pending) begin
                r_half_cur <= r_half_next;
                r_pending  <= 1'b0;
                r_out      <= 1'b0;
                r_cnt      <= 32'd0;
`endif
            end else if (r_cnt == r_half_cur - 32'd1) begin
                r_cnt <= 32'd0;
                if (r_pending) begin
                    r_half_cur <= r_half_next;
                    r_pending  <= 1'b0;
                    r_out      <= (r_half_next == 32'd0) ? 1'b0 : ~r_out;
                end else begin
                    r_out <= ~r_out;
                end
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            // Placed last so a fresh result outranks a same-cycle pending clear
            if (w_zero) begin
                r_half_next <= 32'd0;
                r_pending   <= 1'b1;
            end else if ((r_state == S_DONE) && !w_start) begin
                r_half_next <= w_result;
                r_pending   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_clock_dyn.sv
`default_nettype none
// ============================================================================
// Module  : tb_sub_clock_dyn
// Purpose : Scoreboard bench for sub_clock_dyn at CLK_HZ = 4800.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sub_clock_dyn;

    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic [25:0] Freq = 26'd0;
    logic        OUTCLK;

    int total    = 0;
    int bad      = 0;
    int exp_q[$];
    int cyc      = 0;
    int last_tog = 0;
    int tog_cnt  = 0;
    logic prev_out = 1'b0;
    int n;
    int highs;

    sub_clock_dyn #(.CLK_HZ(32'd4800)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Freq   (Freq),
        .OUTCLK (OUTCLK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each observed edge of OUTCLK closes a half-period; compare against the oldest expectation
    always @(negedge CLK) begin
        cyc++;
        if (OUTCLK !== prev_out) begin
            if (exp_q.size() > 0) chk("half_period", cyc - last_tog, exp_q.pop_front());
            last_tog = cyc;
            tog_cnt++;
            prev_out = OUTCLK;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic push_n(input int v, input int k);
        for (int i = 0; i < k; i++) exp_q.push_back(v);
    endtask

    task automatic wait_tog(input int bound);
        int start;
        int m;
        start = tog_cnt;
        m = 0;
        while (tog_cnt == start && m < bound) begin
            tick();
            m++;
        end
        if (tog_cnt == start) chk("toggle_timeout", 0, 1);
    endtask

    task automatic drain(input int bound);
        int m;
        m = 0;
        while (exp_q.size() > 0 && m < bound) begin
            tick();
            m++;
        end
        if (exp_q.size() > 0) begin
            chk("scoreboard_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic first_toggle_after_release(input string tag);
        @(negedge CLK);
        RST = 1'b0;
        n = 0;
        while (OUTCLK !== 1'b1 && n < 60) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(tag, int'(n <= 46 && OUTCLK === 1'b1), 1);
        tick();
    endtask

    initial begin
        // Reset, then 240 Hz -> half 10
        RST  = 1'b1;
        Freq = 26'd240;
        ticks(3);
        chk("reset_outclk", int'(OUTCLK), 0);
        first_toggle_after_release("first_toggle_by_46");
        push_n(10, 4);
        drain(100);

        // 0 Hz stops the output
        Freq = 26'd0;
        ticks(80);
        highs = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (OUTCLK === 1'b1) highs++;
        end
        chk("zero_freq_highs", highs, 0);

        // Restart from stopped at 120 Hz -> half 20
        Freq = 26'd120;
        wait_tog(120);
        push_n(20, 3);
        drain(200);

        // Saturation: 3000 Hz clamps to half 1, 1600 Hz floors to half 1
        Freq = 26'd3000;
        ticks(80);
        push_n(1, 6);
        drain(20);
        Freq = 26'd1600;
        ticks(60);
        push_n(1, 6);
        drain(20);

        // 240 -> 480 mid half-period: current 10-cycle halves complete, then 5
        Freq = 26'd240;
        ticks(60);
        wait_tog(40);
        Freq = 26'd480;
        push_n(10, 4);
        push_n(5, 3);
        drain(120);

        // 240 -> 100 -> 480 in quick succession: 100 must never show up
        Freq = 26'd240;
        ticks(80);
        wait_tog(40);
        ticks(5);
        Freq = 26'd100;
        wait_tog(40);
        Freq = 26'd480;
        push_n(10, 4);
        push_n(5, 3);
        drain(120);

        // Async reset while OUTCLK is high, then recovery at 240 Hz
        Freq = 26'd240;
        ticks(80);
        n = 0;
        while (OUTCLK !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("outclk_high_before_reset", int'(OUTCLK), 1);
        ticks(3);
        RST = 1'b1;
        #1;
        chk("async_reset_drop", int'(OUTCLK), 0);
        ticks(3);
        first_toggle_after_release("first_toggle_after_rereset");
        push_n(10, 3);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
